pic_stream_ctrl: RTL
====================

Name: pic_stream_ctrl

Overview:
- Sequences the 784-byte picture ROM (28x28, 8-bit pixels, 1-cycle read latency, `valid` flags in-range reads).
- On a start pulse, walks ROM addresses 0..NUM_PIX-1 in raster order and streams the pixels to the downstream recognition datapath over a valid/ready interface with row/col tags.
- Absorbs downstream backpressure with a credit-controlled 2-entry skid FIFO, so no ROM read is ever lost.

Parameters:
- NUM_PIX, 784, pixels per frame; last address is NUM_PIX-1.
- IMG_W, 28, pixels per row; col wraps at IMG_W.
- ADDR_W, 10, ROM address width.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream one frame; ignored unless IDLE.
- abort  in  1  cancel the current frame; ignored in IDLE.
- mem_addr  out  ADDR_W  ROM address.
- mem_dout  in  DATA_W  ROM data, valid 1 cycle after the address.
- mem_valid  in  1  ROM in-range flag, aligned with mem_dout.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts.
- pix_data  out  DATA_W  pixel value.
- pix_row  out  5  row index 0..IMG_W-1.
- pix_col  out  5  column index 0..IMG_W-1.
- pix_last  out  1  marks the final pixel of the frame.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky; set if any returned read had mem_valid=0; cleared on accepted start.

Behaviour:
- **Reset values:** state=IDLE, mem_addr=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, busy=0, done=0, err=0; FIFO empty; issue counter and in-flight flag cleared.
- **States:**
  - IDLE -> RUN on start: clear issue counter, err, and row/col tag counters.
  - RUN -> DRAIN the cycle after address NUM_PIX-1 is issued.
  - DRAIN -> DONE when the final pixel handshakes (pix_valid & pix_ready & pix_last).
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- **Issue rule (RUN only):** an address is issued in cycle t iff fifo_count + inflight - pop(t) < 2.
  - pop(t) = pix_valid & pix_ready.
  - On issue: mem_addr = counter, then counter increments; inflight=1 for the next cycle.
  - When not issuing, mem_addr holds and inflight=0.
  - Full throughput (1 pixel/cycle) when pix_ready is held high.
- **Capture:** when inflight=1, {mem_dout, row, col, last} is written to the FIFO tail that cycle.
  - last is tagged when the captured address = NUM_PIX-1.
  - row/col tag counters advance per capture: col wraps IMG_W-1 -> 0 and increments row.
  - A push and a pop in the same cycle are both legal.
  - Credits guarantee the FIFO never overflows; overflow is an assertion failure.
- **Output:** pix_* reflect the FIFO head; pix_valid = FIFO non-empty. Data and tags hold stable while pix_valid & !pix_ready (AXI-style; no retraction).
- **Latency:** with start sampled at edge T0 and pix_ready=1, pixel k is valid in cycle T0+3+k and pix_last in cycle T0+786; done=1 in cycle T0+787.
- **err:** set on any capture with mem_valid=0. The pixel is still forwarded.
- **abort (RUN/DRAIN):** next state is IDLE. FIFO is flushed, inflight is dropped, pix_valid goes 0 next cycle, no done pulse, err is retained.
- **Precedence:** abort wins over a same-cycle final handshake.
- **start while busy:** ignored, with no effect on the stream.
- **start in the DONE cycle:** also ignored.
- **rst mid-frame:** all state returns to reset values next cycle; any buffered pixels are discarded.

Test Plan:
- Reset, then start with pix_ready=1 -> 784 pixels in consecutive cycles T0+3..T0+786 matching the ROM image. Row/col go (0,0),(0,1)..(0,27),(1,0)..(27,27). pix_last only on (27,27); done=1 at T0+787; busy high T0+1..T0+786.
- pix_ready toggling 1,0,0,1 pseudo-randomly -> no pixel lost or duplicated, data/tags stable while stalled, mem_addr never more than 2 ahead of accepted count, total accepted = 784.
- pix_ready=0 for 50 cycles right after start -> exactly 2 addresses issued (0,1). pix_valid held with pix_data=mem[0]; releasing ready resumes with mem[1],mem[2]...
- abort at pixel 300 with FIFO full -> pix_valid=0 next cycle, no done, state IDLE. A new start then streams from (0,0) with pix_data=mem[0].
- Bench ROM driving mem_valid=0 on address 500 -> err=1 from that capture onward, frame still completes with done. The next start clears err.
- start pulsed during RUN and in the DONE cycle, plus rst asserted at pixel 400 -> starts ignored; after rst all outputs are at reset values and the next start produces a full clean frame.

Source files
------------

// File: rtl/pic_stream_ctrl.sv
// pic_stream_ctrl: streams the picture ROM in raster order with row/col tags through a credit-controlled 2-entry skid FIFO
module pic_stream_ctrl #(
  parameter int NUM_PIX = 784,
  parameter int IMG_W = 28,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_valid,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [4:0]        pix_row,
  output logic [4:0]        pix_col,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt, addr_q;
  logic inflight, s_last, pop, push, issue, cap_last, ld_head, ld_skid;
  logic [1:0] fcnt, fcnt_n;
  logic [2:0] used;
  logic [4:0] row, col, s_row, s_col;
  logic [DATA_W-1:0] s_data;
  assign pop = pix_valid & pix_ready;
  assign push = inflight;
  assign used = {1'b0, fcnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == RUN && !abort && used < 3'd2;
  assign mem_addr = issue ? cnt : addr_q;
  assign cap_last = addr_q == ADDR_W'(NUM_PIX - 1);
  assign fcnt_n = fcnt + {1'b0, push} - {1'b0, pop};
  assign ld_head = (push && (fcnt == 2'd0 || (fcnt == 2'd1 && pop))) || (pop && fcnt == 2'd2);
  assign ld_skid = push && ((fcnt == 2'd1 && !pop) || (fcnt == 2'd2 && pop));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      inflight <= 1'b0;
      fcnt <= 2'd0;
      row <= 5'd0;
      col <= 5'd0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_row <= 5'd0;
      pix_col <= 5'd0;
      pix_last <= 1'b0;
      s_data <= '0;
      s_row <= 5'd0;
      s_col <= 5'd0;
      s_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      inflight <= issue;
      fcnt <= fcnt_n;
      pix_valid <= fcnt_n != 2'd0;
      done <= 1'b0;
      if (issue) begin
        addr_q <= cnt;
        cnt <= cnt + 1'b1;
      end
      if (push) begin
        err <= err | !mem_valid;
        col <= col == 5'(IMG_W - 1) ? 5'd0 : col + 5'd1;
        row <= col == 5'(IMG_W - 1) ? row + 5'd1 : row;
      end
      if (ld_head)
        {pix_data, pix_row, pix_col, pix_last} <= fcnt == 2'd2 ? {s_data, s_row, s_col, s_last}
                                                               : {mem_dout, row, col, cap_last};
      if (ld_skid)
        {s_data, s_row, s_col, s_last} <= {mem_dout, row, col, cap_last};
      if (state == IDLE && start) begin
        state <= RUN;
        busy <= 1'b1;
        cnt <= '0;
        err <= 1'b0;
        row <= 5'd0;
        col <= 5'd0;
      end else if (busy && abort) begin
        state <= IDLE;
        busy <= 1'b0;
        inflight <= 1'b0;
        fcnt <= 2'd0;
        pix_valid <= 1'b0;
      end else if (state == RUN && issue && cnt == ADDR_W'(NUM_PIX - 1)) begin
        state <= DRAIN;
      end else if (state == DRAIN && pop && pix_last) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && fcnt == 2'd2));
endmodule
